// File: rtl/router_1xn_top.sv
// 1-to-N byte-serial packet router: header-addressed per-channel FIFOs,
// parity check, invalid-address drop and per-channel read-timeout flush.
//
// state        | meaning
// S_DECODE     | idle, evaluating the header on data_in
// S_WAIT_EMPTY | header held until its target FIFO has drained
// S_LOAD       | writing payload and parity into the target FIFO
// S_CHECK      | one busy cycle after the parity byte
// S_DROP       | discarding the remainder of a packet
module router_1xn_top #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pkt_valid,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [NUM_CH-1:0]        read_enb,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        vld_out,
  output logic [NUM_CH-1:0]        soft_reset,
  output logic                     busy,
  output logic                     err,
  output logic                     addr_err
);
  localparam int ADDR_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_DECODE, S_WAIT_EMPTY, S_LOAD, S_CHECK, S_DROP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   tgt;
  logic [DATA_W-1:0]   parity;
  logic [ADDR_W-1:0]   hdr_addr;
  logic                hdr_ok;
  logic [NUM_CH-1:0]   full, push, pop, flush;

  assign hdr_addr = data_in[ADDR_W-1:0];
  assign hdr_ok   = int'(hdr_addr) < NUM_CH;

  always_comb begin
    busy = 1'b0;
    case (state)
      S_WAIT_EMPTY, S_CHECK: busy = 1'b1;
      S_LOAD:                busy = full[tgt];
      default:               busy = 1'b0;
    endcase
  end

  always_comb begin
    push = '0;
    if (state == S_DECODE && pkt_valid && hdr_ok && !vld_out[hdr_addr])
      push[hdr_addr] = 1'b1;
    else if (state == S_LOAD && !full[tgt])
      push[tgt] = 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic [TMR_W-1:0]  tmr;
    logic              sr_q;

    assign vld_out[i]    = wr_ptr != rd_ptr;
    assign full[i]       = (wr_ptr - rd_ptr) == FULL_CNT;
    assign pop[i]        = read_enb[i] && vld_out[i];
    assign flush[i]      = vld_out[i] && !read_enb[i] && tmr == TMR_LAST;
    assign soft_reset[i] = sr_q;
    assign data_out[i*DATA_W +: DATA_W] = vld_out[i] ? mem[rd_ptr[PTR_W-1:0]] : '0;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        tmr    <= '0;
        sr_q   <= 1'b0;
      end else begin
        sr_q <= flush[i];
        if (flush[i]) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          tmr    <= '0;
        end else begin
          if (push[i]) wr_ptr <= wr_ptr + 1'b1;
          if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
          if (pop[i] || !vld_out[i]) tmr <= '0;
          else                       tmr <= tmr + 1'b1;
        end
      end
    end

    // flush wins over a same-edge push, so the byte is never stored
    always_ff @(posedge clock) begin
      if (push[i] && !flush[i]) mem[wr_ptr[PTR_W-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_DECODE;
      tgt      <= '0;
      parity   <= '0;
      err      <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        S_DECODE: if (pkt_valid) begin
          if (!hdr_ok) begin
            addr_err <= 1'b1;
            state    <= S_DROP;
          end else begin
            tgt <= hdr_addr;
            if (!vld_out[hdr_addr]) begin
              parity   <= data_in;
              err      <= 1'b0;
              addr_err <= 1'b0;
              state    <= S_LOAD;
            end else begin
              state <= S_WAIT_EMPTY;
            end
          end
        end
        S_WAIT_EMPTY: if (!vld_out[tgt]) state <= S_DECODE;
        // a flushed target abandons the packet; if the parity byte was just
        // consumed there is nothing left to discard
        S_LOAD: if (flush[tgt]) begin
          state <= (pkt_valid || full[tgt]) ? S_DROP : S_DECODE;
        end else if (!full[tgt]) begin
          if (pkt_valid) begin
            parity <= parity ^ data_in;
          end else begin
            err   <= data_in != parity;
            state <= S_CHECK;
          end
        end
        S_CHECK: state <= S_DECODE;
        S_DROP:  if (!pkt_valid) state <= S_DECODE;
        default: state <= S_DECODE;
      endcase
    end
  end
endmodule

// File: tb/tb_router_1xn_top.sv
// Bench for router_1xn_top (3-channel build): queue-based reference model
// checked every cycle, plus directed scenarios and a randomized packet phase.
module tb_router_1xn_top;
  localparam int NCH = 3, DW = 8, DEPTH = 16, TIMEOUT = 30, AW = 2;
  localparam int M_DEC = 0, M_WAIT = 1, M_LOAD = 2, M_CHECK = 3, M_DROP = 4;

  logic              clock = 1'b0, reset = 1'b1, pkt_valid = 1'b0;
  logic [DW-1:0]     data_in = '0;
  logic [NCH-1:0]    read_enb = '0;
  logic [NCH*DW-1:0] data_out;
  logic [NCH-1:0]    vld_out, soft_reset;
  logic              busy, err, addr_err;

  router_1xn_top #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .vld_out(vld_out),
    .soft_reset(soft_reset), .busy(busy), .err(err), .addr_err(addr_err));

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  logic [7:0] mq[NCH][$];
  int tmr[NCH];
  int mode, tgt;
  logic [7:0] par;
  bit m_err, m_aerr;
  logic [NCH-1:0] m_sr;
  logic [7:0] src_d[$];
  bit src_v[$];
  logic [7:0] got[NCH][$];
  logic [7:0] last_pkt[$], fixed_pl[$], expq[$];
  int rd_pct = 0;
  logic [NCH-1:0] rd_mask = '1;
  int busy_hi_cnt = 0;
  int sr_cnt[NCH];
  logic [7:0] exp1[6] = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46};
  int pcts[4] = '{0, 30, 70, 100};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin mq[c].delete(); tmr[c] = 0; end
    mode = M_DEC; tgt = 0; par = '0; m_err = 0; m_aerr = 0; m_sr = '0;
  endtask

  task automatic check_outputs();
    logic [NCH*DW-1:0] e_do;
    logic [NCH-1:0] e_v;
    bit e_b;
    e_do = '0;
    for (int c = 0; c < NCH; c++) begin
      e_v[c] = mq[c].size() > 0;
      e_do[c*DW +: DW] = e_v[c] ? mq[c][0] : 8'h00;
    end
    e_b = (mode == M_WAIT) || (mode == M_CHECK) || (mode == M_LOAD && mq[tgt].size() == DEPTH);
    chk("vld_out", vld_out, e_v);
    chk("data_out", data_out, e_do);
    chk("busy", busy, e_b);
    chk("err", err, m_err);
    chk("addr_err", addr_err, m_aerr);
    chk("soft_reset", soft_reset, m_sr);
  endtask

  task automatic set_rd(input logic [NCH-1:0] mask, input int pct);
    rd_mask = mask; rd_pct = pct;
    for (int c = 0; c < NCH; c++) read_enb[c] = rd_mask[c] && ($urandom_range(99) < rd_pct);
  endtask

  task automatic drive();
    if (src_d.size() > 0) begin pkt_valid = src_v[0]; data_in = src_d[0]; end
    else begin pkt_valid = 1'b0; data_in = 8'($urandom); end
    set_rd(rd_mask, rd_pct);
  endtask

  task automatic add_pkt(input logic [7:0] hdr, input int len, input bit bad);
    logic [7:0] p, b;
    last_pkt.delete();
    p = hdr;
    src_d.push_back(hdr); src_v.push_back(1'b1); last_pkt.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      b = (i < fixed_pl.size()) ? fixed_pl[i] : 8'($urandom);
      p ^= b;
      src_d.push_back(b); src_v.push_back(1'b1); last_pkt.push_back(b);
    end
    p = bad ? (p ^ 8'h01) : p;
    src_d.push_back(p); src_v.push_back(1'b0); last_pkt.push_back(p);
    drive();
  endtask

  // one clock: model consumes the current inputs, DUT takes the edge, outputs compared
  task automatic step();
    bit cons, tf, vpre, popped;
    logic [NCH-1:0] fl;
    int push_ch, a;
    for (int c = 0; c < NCH; c++)
      if (read_enb[c] && vld_out[c]) got[c].push_back(data_out[c*DW +: DW]);
    for (int c = 0; c < NCH; c++)
      fl[c] = (mq[c].size() > 0) && !read_enb[c] && tmr[c] == TIMEOUT - 1;
    cons = 0; push_ch = -1;
    a = int'(data_in[AW-1:0]);
    case (mode)
      M_DEC: if (pkt_valid) begin
        if (a >= NCH) begin m_aerr = 1; mode = M_DROP; cons = 1; end
        else begin
          tgt = a;
          if (mq[a].size() == 0) begin
            push_ch = a; par = data_in; m_err = 0; m_aerr = 0; mode = M_LOAD; cons = 1;
          end else mode = M_WAIT;
        end
      end
      M_WAIT: if (mq[tgt].size() == 0) mode = M_DEC;
      M_LOAD: begin
        tf = mq[tgt].size() == DEPTH;
        if (!tf) begin cons = 1; push_ch = tgt; end
        if (fl[tgt]) mode = (pkt_valid || tf) ? M_DROP : M_DEC;
        else if (!tf) begin
          if (pkt_valid) par ^= data_in;
          else begin m_err = (data_in != par); mode = M_CHECK; end
        end
      end
      M_CHECK: mode = M_DEC;
      M_DROP: begin cons = 1; if (!pkt_valid) mode = M_DEC; end
      default: mode = M_DEC;
    endcase
    for (int c = 0; c < NCH; c++) begin
      if (fl[c]) begin mq[c].delete(); tmr[c] = 0; end
      else begin
        vpre = mq[c].size() > 0;
        popped = read_enb[c] && vpre;
        tmr[c] = (popped || !vpre) ? 0 : tmr[c] + 1;
        if (popped) void'(mq[c].pop_front());
        if (push_ch == c) mq[c].push_back(data_in);
      end
    end
    m_sr = fl;
    @(posedge clock); #1;
    if (cons && src_d.size() > 0) begin void'(src_d.pop_front()); void'(src_v.pop_front()); end
    check_outputs();
    if (busy) busy_hi_cnt++;
    for (int c = 0; c < NCH; c++) if (soft_reset[c]) sr_cnt[c]++;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_idle(input int max_c);
    int n = 0;
    while (!(src_d.size() == 0 && mode == M_DEC) && n < max_c) begin step(); n++; end
    chk("idle_bound", (src_d.size() == 0 && mode == M_DEC), 1);
  endtask

  task automatic cmp_got(input string tag, input int ch);
    chk({tag, "_len"}, got[ch].size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < got[ch].size()) ? 64'(got[ch][i]) : 64'hFFFF, expq[i]);
  endtask

  initial begin
    int n, rise, srk, seen, np;
    bit vchk, pb;
    for (int c = 0; c < NCH; c++) sr_cnt[c] = 0;
    model_reset();
    #1;
    check_outputs();
    #20;
    @(negedge clock);
    reset = 1'b0;
    drive();

    // good 4-payload packet to ch2
    fixed_pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    busy_hi_cnt = 0;
    add_pkt(8'h02, 4, 0);
    run_idle(20);
    chk("t1_busy_cycles", busy_hi_cnt, 1);
    chk("t1_err", err, 0);
    for (int c = 0; c < NCH; c++) got[c].delete();
    set_rd(3'b100, 100); run(8); set_rd('1, 0);
    expq.delete();
    foreach (exp1[i]) expq.push_back(exp1[i]);
    cmp_got("t1", 2);

    // bad parity sets err, next good header clears it
    add_pkt(8'h02, 4, 1);
    run_idle(20);
    chk("t2_err_set", err, 1);
    fixed_pl.delete();
    add_pkt(8'h00, 2, 0);
    run_idle(20);
    chk("t2_err_clr", err, 0);
    set_rd('1, 100); run(10); set_rd('1, 0);

    // invalid address 3 is dropped
    busy_hi_cnt = 0;
    add_pkt(8'h07, 2, 0);
    run_idle(20);
    chk("t3_addr_err", addr_err, 1);
    chk("t3_vld", vld_out, 0);
    chk("t3_busy", busy_hi_cnt, 0);

    // 20-byte payload fills ch0 and back-pressures
    got[0].delete();
    add_pkt(8'h00, 20, 0);
    expq = last_pkt;
    n = 0;
    while (!busy && n < 40) begin step(); n++; end
    chk("t4_rise_cycle", n, 16);
    set_rd(3'b001, 100); step();
    chk("t4_busy_after_pop", busy, 0);
    set_rd('1, 0); step();
    chk("t4_busy_refill", busy, 1);
    set_rd(3'b001, 100); run_idle(60); run(20); set_rd('1, 0);
    cmp_got("t4", 0);
    chk("t4_err", err, 0);

    // unread ch0 while loading: timeout flush aborts into drop
    sr_cnt[0] = 0;
    add_pkt(8'h00, 20, 0);
    run_idle(80);
    chk("t4b_flush_cnt", sr_cnt[0], 1);
    chk("t4b_vld", vld_out[0], 0);
    chk("t4b_addr_err", addr_err, 0);
    chk("t4b_err", err, 0);

    // timeout of an idle channel
    add_pkt(8'h01, 1, 0);
    rise = -1; srk = -1; vchk = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      step();
      if (vld_out[1] && rise < 0) rise = k;
      if (soft_reset[1]) begin srk = k; vchk = vld_out[1]; break; end
    end
    chk("t5_sr_delay", srk - rise, TIMEOUT);
    chk("t5_vld_cleared", vchk, 0);
    add_pkt(8'h01, 1, 0);
    n = 0;
    while (!vld_out[1] && n < 10) begin step(); n++; end
    chk("t5_rise", vld_out[1], 1);
    seen = 0;
    repeat (28) begin step(); if (soft_reset[1]) seen = 1; end
    set_rd(3'b010, 100); step(); set_rd('1, 0);
    repeat (15) begin step(); if (soft_reset[1]) seen = 1; end
    chk("t5_no_flush", seen, 0);
    set_rd('1, 100); run(5); set_rd('1, 0);

    // second packet to a non-empty channel waits
    got[1].delete();
    add_pkt(8'h01, 2, 0);
    expq = last_pkt;
    add_pkt(8'h01, 1, 0);
    foreach (last_pkt[i]) expq.push_back(last_pkt[i]);
    n = 0; pb = 0;
    while (!(busy && pb) && n < 20) begin pb = busy; step(); n++; end
    chk("t6_wait_busy", busy, 1);
    busy_hi_cnt = 0;
    run(8);
    chk("t6_busy_held", busy_hi_cnt, 8);
    set_rd(3'b010, 100); run_idle(40); run(8); set_rd('1, 0);
    cmp_got("t6", 1);

    // randomized packets
    for (int p = 0; p < 40; p++) begin
      np = $urandom_range(1, 2);
      set_rd('1, pcts[$urandom_range(0, 3)]);
      for (int j = 0; j < np; j++)
        add_pkt({6'($urandom), 2'($urandom_range(0, 3))}, $urandom_range(0, 20), $urandom_range(0, 3) == 0);
      run_idle(250);
      run($urandom_range(0, 3));
    end

    // asynchronous reset in the middle of LOAD
    set_rd('1, 100); run(20); set_rd('1, 0);
    add_pkt(8'h02, 10, 0);
    n = 0;
    while (!(mode == M_LOAD && mq[2].size() >= 3) && n < 20) begin step(); n++; end
    chk("t8_in_load", vld_out[2], 1);
    #2 reset = 1'b1;
    #1;
    src_d.delete(); src_v.delete();
    model_reset();
    check_outputs();
    @(negedge clock);
    reset = 1'b0;
    drive();
    add_pkt(8'h01, 3, 0);
    set_rd('1, 100);
    run_idle(40);
    run(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
